// File: rtl/axi_arb_pkg.sv
// Shared types and encodings for the AXI write/read channel arbiters.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin picker: the lowest requester above
// last_grant wins, otherwise the lowest requester overall.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] gnt
);

    logic [NREQ-1:0] above;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pool;

    always_comb begin
        above = '0;
        for (int i = 0; i < NREQ; i++) begin
            above[i] = (IDXW'(i) > last_grant);
        end
        req_hi = req & above;
        pool   = (req_hi != '0) ? req_hi : req;
        // Two's-complement trick isolates the lowest set bit of the pool.
        gnt    = pool & (~pool + NREQ'(1));
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write channel (AW/W/B) between NREQ
// requesters; owns one whole transaction at a time and generates wlast.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           s_awvalid,
    output logic [NREQ-1:0]           s_awready,
    input  logic [NREQ*AW-1:0]        s_awaddr,
    input  logic [NREQ*LEN_W-1:0]     s_awlen,
    input  logic [NREQ*SIZE_W-1:0]    s_awsize,
    input  logic [NREQ*BURST_W-1:0]   s_awburst,
    input  logic [NREQ-1:0]           s_wvalid,
    output logic [NREQ-1:0]           s_wready,
    input  logic [NREQ*DW-1:0]        s_wdata,
    input  logic [NREQ*(DW/8)-1:0]    s_wstrb,
    output logic [NREQ-1:0]           s_bvalid,
    input  logic [NREQ-1:0]           s_bready,
    output logic [RESP_W-1:0]         s_bresp,
    output logic [AW-1:0]             m_awaddr,
    output logic [LEN_W-1:0]          m_awlen,
    output logic [SIZE_W-1:0]         m_awsize,
    output logic [BURST_W-1:0]        m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DW-1:0]             m_wdata,
    output logic [DW/8-1:0]           m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [RESP_W-1:0]         m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [NREQ-1:0]           grant,
    output logic                      busy,
    output arb_state_e                dbg_state
);

    localparam int SW   = DW / 8;
    localparam int IDXW = $clog2(NREQ);

    // valid/ready: a transfer happens on the rising edge where both are high;
    // a raised valid holds its payload stable until that edge.

    arb_state_e           state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [IDXW-1:0]      gidx_q, gidx_d;
    logic [IDXW-1:0]      last_q, last_d;
    logic [AW-1:0]        awaddr_q, awaddr_d;
    logic [LEN_W-1:0]     awlen_q, awlen_d;
    logic [SIZE_W-1:0]    awsize_q, awsize_d;
    logic [BURST_W-1:0]   awburst_q, awburst_d;
    logic                 awvalid_q, awvalid_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;

    logic [NREQ-1:0]      pick;
    logic [IDXW-1:0]      pick_idx;
    logic                 aw_hs, w_hs, b_hs;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req        (s_awvalid),
        .last_grant (last_q),
        .gnt        (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IDXW'(i);
        end
    end

    assign aw_hs = awvalid_q & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = (state_q == RESP) & m_bvalid & m_bready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        awvalid_d = awvalid_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|s_awvalid) begin
                    grant_d   = pick;
                    gidx_d    = pick_idx;
                    awvalid_d = 1'b1;
                    state_d   = ADDR;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick[i]) begin
                            awaddr_d  = s_awaddr[i*AW +: AW];
                            awlen_d   = s_awlen[i*LEN_W +: LEN_W];
                            awsize_d  = s_awsize[i*SIZE_W +: SIZE_W];
                            awburst_d = s_awburst[i*BURST_W +: BURST_W];
                        end
                    end
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    cnt_d     = awlen_q;
                    state_d   = DATA;
                end
            end
            DATA: begin
                // cnt counts remaining beats minus one, so awlen=255 never wraps.
                if (w_hs) begin
                    if (cnt_q == '0) state_d = RESP;
                    else             cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            RESP: begin
                if (b_hs) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                case (state_q)
                    ADDR: s_awready[i] = m_awready;
                    DATA: begin
                        m_wvalid    = s_wvalid[i];
                        s_wready[i] = m_wready;
                        m_wdata     = s_wdata[i*DW +: DW];
                        m_wstrb     = s_wstrb[i*SW +: SW];
                        m_wlast     = (cnt_q == '0);
                    end
                    RESP: begin
                        s_bvalid[i] = m_bvalid;
                        s_bresp     = m_bresp;
                        m_bready    = s_bready[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IDXW'(NREQ - 1);
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            awvalid_q <= awvalid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = awsize_q;
    assign m_awburst = awburst_q;
    assign m_awvalid = awvalid_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
